// File: rtl/arb4_pkg.sv
// Shared definitions for the four-requester burst arbiter: state encoding,
// widths and the round-robin pointer/priority helpers.
package arb4_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;
   localparam int CNT_W = 8;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

   // First set request scanning ptr, ptr+1, ... with wrap; ptr when none set.
   function automatic logic [IDX_W-1:0] pick_first(input logic [N_REQ-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      pick_first = ptr;
      found      = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + IDX_W'(i);
         if (!found && req[idx]) begin
            pick_first = idx;
            found      = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux4_1.sv
// Four-to-one single-bit data multiplexer.
module mux4_1 (
   input  logic [1:0] s,
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   output logic       y
);

   // Select one of the four data bits.
   always_comb begin
      y = 1'b0;
      case (s)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         2'd3:    y = d3;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/arb4_sched.sv
// Round-robin four-requester burst arbiter with a single-bit data path.
// Optional per-requester burst lock is built when ARB4_LOCK_EN is defined.
module arb4_sched #(
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       in3,
   input  logic       out_ready,
`ifdef ARB4_LOCK_EN
   input  logic [3:0] lock,
`endif
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       out,
   output logic       out_valid,
   output logic [3:0] ack,
   output logic       busy
);

   import arb4_pkg::*;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   state_t             state_r;
   state_t             state_s;
   logic [IDX_W-1:0]   ptr_r;
   logic [IDX_W-1:0]   sel_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               mux_y_s;
   logic               locked_s;
   logic               transfer_s;
   logic               withdraw_s;
   logic               end_burst_s;

`ifdef ARB4_LOCK_EN
   assign locked_s = lock[sel_r];
`else
   assign locked_s = 1'b0;
`endif

   mux4_1 u_mux (
      .s  (sel_r),
      .d0 (in0),
      .d1 (in1),
      .d2 (in2),
      .d3 (in3),
      .y  (mux_y_s)
   );

   // Beat handshake and burst-termination conditions; a lock keeps the burst open.
   always_comb begin
      transfer_s  = (state_r == GRANT) && req[sel_r] && out_ready;
      withdraw_s  = (state_r == GRANT) && !req[sel_r];
      end_burst_s = transfer_s && (cnt_r == LAST_BEAT) && !locked_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; leaving GRANT always lands in IDLE, giving the bubble.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (|req) begin
               state_s = GRANT;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (withdraw_s || end_burst_s) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Pointer, selected index and beat counter; cnt saturates on the last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= {IDX_W{1'b0}};
         sel_r <= {IDX_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (|req) begin
                  sel_r <= pick_first(req, ptr_r);
                  cnt_r <= {CNT_W{1'b0}};
               end
            end
            GRANT: begin
               if (withdraw_s || end_burst_s) begin
                  ptr_r <= next_ptr(sel_r);
                  cnt_r <= {CNT_W{1'b0}};
               end else if (transfer_s && (cnt_r != LAST_BEAT)) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               ptr_r <= {IDX_W{1'b0}};
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Output decode; data and handshake follow req/out_ready combinationally.
   always_comb begin
      gnt       = 4'b0000;
      ack       = 4'b0000;
      out       = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
         end
         GRANT: begin
            gnt       = 4'b0001 << sel_r;
            out       = mux_y_s;
            out_valid = req[sel_r];
            busy      = 1'b1;
            if (transfer_s) begin
               ack = 4'b0001 << sel_r;
            end else begin
               ack = 4'b0000;
            end
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign sel = sel_r;

endmodule

// File: tb/tb_arb4_sched.sv
// Directed self-checking bench for arb4_sched (default BURST_LEN=4);
// the lock scenario is compiled in when ARB4_LOCK_EN is defined.
module tb_arb4_sched;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] inpat;
   logic       out_ready;
   logic [3:0] lock;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       out;
   logic       out_valid;
   logic [3:0] ack;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   arb4_sched #(.BURST_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in0       (inpat[0]),
      .in1       (inpat[1]),
      .in2       (inpat[2]),
      .in3       (inpat[3]),
      .out_ready (out_ready),
`ifdef ARB4_LOCK_EN
      .lock      (lock),
`endif
      .sel       (sel),
      .gnt       (gnt),
      .out       (out),
      .out_valid (out_valid),
      .ack       (ack),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"},  gnt, 4'b0000);
      chk({tag, "_ack"},  ack, 4'b0000);
      chk({tag, "_busy"}, 4'(busy), 4'd0);
      chk({tag, "_vld"},  4'(out_valid), 4'd0);
      chk({tag, "_out"},  4'(out), 4'd0);
   endtask

   initial begin
      logic [3:0] exp_oh;
      int         gi;

      rst       = 1'b1;
      req       = 4'b0000;
      inpat     = 4'b0000;
      out_ready = 1'b0;
      lock      = 4'b0000;
      #1;
      chk_idle("reset");
      chk("reset_sel", 4'(sel), 4'd0);
      tick();
      tick();
      rst = 1'b0;

      // Reset release, req=1010 -> requester 1 one cycle later
      req = 4'b1010;
      #1;
      chk("r30_pre_gnt", gnt, 4'b0000);
      tick();
      chk("r30_gnt", gnt, 4'b0010);
      chk("r30_sel", 4'(sel), 4'd1);
      chk("r30_busy", 4'(busy), 4'd1);
      inpat = 4'b0010;
      #1;
      chk("r30_out", 4'(out), 4'd1);
      chk("r30_vld", 4'(out_valid), 4'd1);
      chk("r30_ack_nordy", ack, 4'b0000);
      out_ready = 1'b1;
      #1;
      chk("r30_ack", ack, 4'b0010);
      req = 4'b0000;
      #1;
      chk("r30_wd_ack", ack, 4'b0000);
      chk("r30_wd_vld", 4'(out_valid), 4'd0);
      tick();
      chk_idle("r30_idle");
      chk("r30_sel_hold", 4'(sel), 4'd1);

      // Round robin over all four with full bursts
      rst = 1'b1;
      #1;
      rst = 1'b0;
      chk("rr_sel_rst", 4'(sel), 4'd0);
      req       = 4'b1111;
      out_ready = 1'b1;
      inpat     = 4'b0101;
      for (int g = 0; g < 5; g++) begin
         gi     = g % 4;
         exp_oh = 4'b0001 << gi;
         tick();
         chk("rr_sel", 4'(sel), 4'(gi));
         for (int b = 0; b < 4; b++) begin
            chk("rr_gnt", gnt, exp_oh);
            chk("rr_ack", ack, exp_oh);
            chk("rr_out", 4'(out), 4'(inpat[gi]));
            tick();
         end
         chk("rr_bubble_gnt", gnt, 4'b0000);
         chk("rr_bubble_busy", 4'(busy), 4'd0);
      end
      req = 4'b0000;

      // Grant to 2 with a 5-cycle sink stall after the first beat
      req = 4'b0100;
      tick();
      chk("st_gnt", gnt, 4'b0100);
      chk("st_ack0", ack, 4'b0100);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("st_hold_gnt", gnt, 4'b0100);
         chk("st_hold_ack", ack, 4'b0000);
         chk("st_hold_vld", 4'(out_valid), 4'd1);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st_resume_ack", ack, 4'b0100);
         tick();
      end
      chk("st_end_gnt", gnt, 4'b0000);
      req = 4'b0000;

      // Grant to 3, withdrawn after two beats; ptr must move to 0
      req = 4'b1010;
      tick();
      chk("wd_sel", 4'(sel), 4'd3);
      chk("wd_ack0", ack, 4'b1000);
      tick();
      chk("wd_ack1", ack, 4'b1000);
      tick();
      req = 4'b0010;
      #1;
      chk("wd_drop_ack", ack, 4'b0000);
      chk("wd_drop_vld", 4'(out_valid), 4'd0);
      chk("wd_drop_gnt", gnt, 4'b1000);
      tick();
      chk("wd_idle_gnt", gnt, 4'b0000);
      req = 4'b1001;
      tick();
      chk("wd_ptr_sel", 4'(sel), 4'd0);
      chk("wd_ptr_gnt", gnt, 4'b0001);
      req = 4'b0000;
      tick();
      chk("wd_end_gnt", gnt, 4'b0000);

      // Reset pulsed mid-burst at cnt=2
      req = 4'b0101;
      tick();
      chk("mr_sel", 4'(sel), 4'd2);
      tick();
      tick();
      chk("mr_gnt_pre", gnt, 4'b0100);
      rst = 1'b1;
      #1;
      chk_idle("mr_rst");
      chk("mr_rst_sel", 4'(sel), 4'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_first_sel", 4'(sel), 4'd0);
      chk("mr_first_gnt", gnt, 4'b0001);
      req = 4'b0000;
      tick();
      chk("mr_end_gnt", gnt, 4'b0000);

`ifdef ARB4_LOCK_EN
      // Locked burst to 1 stays granted beyond BURST_LEN until withdrawn
      rst = 1'b1;
      #1;
      rst       = 1'b0;
      req       = 4'b0010;
      lock      = 4'b0010;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("lk_gnt", gnt, 4'b0010);
         chk("lk_ack", ack, 4'b0010);
         tick();
      end
      chk("lk_still_gnt", gnt, 4'b0010);
      req = 4'b0000;
      #1;
      chk("lk_drop_ack", ack, 4'b0000);
      tick();
      chk("lk_release_gnt", gnt, 4'b0000);
      lock = 4'b0000;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/arb4_sched.md
ARB4_SCHED -- requirements
Module: arb4_sched

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, which sets the maximum beats per grant before forced rotation (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request, which also serves as beat-valid.
REQ-005 The block SHALL have ports in0, in1, in2 and in3, input, 1 bit each: requester data bits.
REQ-006 The block SHALL have port out_ready, input, 1 bit: sink accepts the current beat.
REQ-007 The block SHALL have port lock, input, 4 bits: per-requester burst lock, present only when ARB4_LOCK_EN is defined.
REQ-008 The block SHALL have port sel, output, 2 bits: granted requester index, which drives the data mux select.
REQ-009 The block SHALL have port gnt, output, 4 bits: one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port out, output, 1 bit: data of the granted requester.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out holds a valid beat.
REQ-012 The block SHALL have port ack, output, 4 bits: one-hot beat-accepted strobe to the requester.
REQ-013 The block SHALL have port busy, output, 1 bit: high in GRANT state.

Function
REQ-014 The block SHALL use two states: IDLE and GRANT; a round-robin pointer ptr (2 bits); and a beat counter cnt (8 bits).
REQ-015 In IDLE: gnt=0, out_valid=0, ack=0, busy=0, and out=0; sel SHALL hold its last value.
REQ-016 In IDLE with req!=0, the next edge SHALL enter GRANT, granting the first set req bit in cyclic order ptr, ptr+1, ... (index 3 wraps to 0), and clear cnt; req-to-gnt latency is exactly 1 cycle.
REQ-017 In GRANT: out=in[sel] and out_valid=req[sel], both combinational; transfer=out_valid&out_ready; ack[sel]=transfer; all other ack bits 0.
REQ-018 On transfer with cnt<BURST_LEN-1, cnt SHALL increment; when out_ready=0, cnt, sel and gnt SHALL hold indefinitely.
REQ-019 On transfer with cnt==BURST_LEN-1, the next state SHALL be IDLE, ptr SHALL become sel+1 mod 4, and cnt SHALL become 0.
REQ-020 When req[sel]=0 in GRANT (withdrawal), the block SHALL generate no ack, go to IDLE next edge, and set ptr=sel+1 mod 4.
REQ-021 Every GRANT-to-GRANT handover SHALL pass through exactly one IDLE cycle (bubble); no direct re-grant.
REQ-022 Requests rising during GRANT SHALL be ignored until the next IDLE evaluation; gnt SHALL never have more than one bit set.
REQ-023 With BURST_LEN=1, every grant SHALL last exactly one accepted beat.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, gnt=0, ack=0, out_valid=0, busy=0, out=0, sel=0, ptr=0, and cnt=0, including mid-burst.
REQ-025 The first arbitration after reset SHALL occur on the first rising edge with rst low; requester 0 has first priority.

Configuration
REQ-026 Macro ARB4_LOCK_EN defined: the lock port SHALL exist, and while lock[sel]=1 in GRANT the REQ-019 release SHALL be suppressed (cnt saturates at BURST_LEN-1), leaving release only by withdrawal.
REQ-027 Macro ARB4_LOCK_EN undefined: the lock port SHALL be absent and the block SHALL behave per REQ-019 unconditionally.

Structure
REQ-028 Shared package arb4_pkg SHALL hold: state encoding (IDLE=0, GRANT=1), N_REQ=4, IDX_W=2, CNT_W=8, and a next-pointer/priority-pick function.
REQ-029 The data path SHALL be one instance of the existing mux4_1 sub-module (select=sel), gated to 0 in IDLE.

Verification
REQ-030 The bench SHALL cover: reset release, req=4'b1010 -> gnt=4'b0010 one cycle later, sel=1.
REQ-031 The bench SHALL cover: req=4'b1111 held, out_ready=1, BURST_LEN=4 -> grants 0,1,2,3,0 with 4 acks each and one IDLE bubble between grants.
REQ-032 The bench SHALL cover: during grant to 2, out_ready=0 for 5 cycles -> cnt, gnt frozen, ack=0; resume -> remaining beats complete.
REQ-033 The bench SHALL cover: grant to 3, req[3] dropped after 2 beats -> IDLE next edge, ptr=0, no ack on drop cycle.
REQ-034 The bench SHALL cover: rst pulsed mid-burst (cnt=2) -> gnt=0 immediately, then first grant goes to the lowest set req index from 0.
REQ-035 The bench SHALL cover, with ARB4_LOCK_EN: lock[1]=1, req[1] held 10 beats -> gnt stays 4'b0010 for all 10 beats; req[1] dropped -> release.
